// File: rtl/fifo_drain_pkg.sv
// Shared types and width helpers for the FIFO burst drain block.
package fifo_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Beat counter must reach BURST_LEN itself, so one extra code point.
  function automatic int unsigned beat_cnt_width(input int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

  // Idle/wait timers saturate at TIMEOUT_CYCLES-1.
  function automatic int unsigned timer_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles);
  endfunction

endpackage

// File: rtl/drain_out_reg.sv
// Single-entry valid/ready output register: load, hold under backpressure, clear on accept.
module drain_out_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  // Load a new beat when told to; otherwise drop valid once the beat is taken.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/fifo_burst_drain.sv
// Pops words from the FIFO and re-emits them as bursts of up to BURST_LEN beats.
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  fifo_empty_ind,
  input  logic                  fifo_threshold_ind,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_trans_read,
  input  logic                  flush_req,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int unsigned BCW = beat_cnt_width(BURST_LEN);
  localparam int unsigned TW  = timer_width(TIMEOUT_CYCLES);

  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);
  localparam logic [BCW-1:0] BEAT_MAX  = BCW'(BURST_LEN);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  drain_state_e          r_state;
  drain_state_e          w_state_nxt;
  logic [BCW-1:0]        r_beat_cnt;
  logic [TW-1:0]         r_idle_cnt;
  logic [TW-1:0]         r_wait_cnt;
  logic                  r_hold_valid;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [BCW-1:0]        r_hold_idx;
  logic                  r_flush_mode;

  logic w_out_free;
  logic w_is_last;
  logic w_release;
  logic w_pop;
  logic w_enter_drain;

  assign w_out_free    = !m_valid || m_ready;
  assign w_is_last     = (r_hold_idx == BEAT_LAST) ||
                         (fifo_empty_ind && (r_flush_mode || (r_wait_cnt == TMO_LAST)));
  assign w_release     = r_hold_valid && w_out_free && (w_is_last || !fifo_empty_ind);
  assign w_pop         = (r_state == DRAIN) && !fifo_empty_ind && (r_beat_cnt < BEAT_MAX) &&
                         (!r_hold_valid || w_release);
  assign w_enter_drain = (r_state == IDLE) && (w_state_nxt == DRAIN);

  assign fifo_trans_read = w_pop;
  assign busy            = (r_state != IDLE) || m_valid || r_hold_valid;

  // State register.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state: start a burst on threshold, flush or idle timeout; end it on the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!fifo_empty_ind &&
            (fifo_threshold_ind || flush_req || r_flush_mode || (r_idle_cnt == TMO_LAST)))
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_release && w_is_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Idle timer: runs while data sits in the FIFO without a burst in progress.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      r_idle_cnt <= '0;
    end else if ((r_state == IDLE) && !fifo_empty_ind) begin
      if (r_idle_cnt != TMO_LAST) r_idle_cnt <= r_idle_cnt + TW'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end

  // Wait timer: how long the held word has waited for a successor.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      r_wait_cnt <= '0;
    end else if (w_enter_drain || w_pop) begin
      r_wait_cnt <= '0;
    end else if (r_hold_valid && fifo_empty_ind && !w_is_last && (r_wait_cnt != TMO_LAST)) begin
      r_wait_cnt <= r_wait_cnt + TW'(1);
    end
  end

  // Beat counter: words popped in the current burst.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b)          r_beat_cnt <= '0;
    else if (w_enter_drain) r_beat_cnt <= '0;
    else if (w_pop)         r_beat_cnt <= r_beat_cnt + BCW'(1);
  end

  // Hold stage: delays each word one cycle so its last-beat status is known.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_idx   <= '0;
    end else if (w_pop) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= fifo_data;
      r_hold_idx   <= r_beat_cnt;
    end else if (w_release) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Flush mode: keep draining until the FIFO is empty and the final beat is out.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      r_flush_mode <= 1'b0;
    end else if (flush_req) begin
      r_flush_mode <= 1'b1;
    end else if ((w_release && w_is_last && fifo_empty_ind) ||
                 ((r_state == IDLE) && fifo_empty_ind)) begin
      r_flush_mode <= 1'b0;
    end
  end

  drain_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk_in  (clk_in),
    .areset_b(areset_b),
    .i_load  (w_release),
    .i_data  (r_hold_data),
    .i_last  (w_is_last),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_last  (m_last)
  );

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain with a behavioural FIFO on the input side.
module tb_fifo_burst_drain;

  logic        clk_in = 1'b0;
  logic        areset_b = 1'b0;
  logic        fifo_empty_ind;
  logic        fifo_threshold_ind = 1'b0;
  logic [31:0] fifo_data;
  logic        fifo_trans_read;
  logic        flush_req = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;

  logic [31:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          npops  = 0;
  int          nbeats = 0;
  logic [31:0] bdata [64];
  logic        blast [64];

  int n_chk  = 0;
  int n_pass = 0;

  fifo_burst_drain #(
    .DATA_WIDTH(32),
    .BURST_LEN(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in            (clk_in),
    .areset_b          (areset_b),
    .fifo_empty_ind    (fifo_empty_ind),
    .fifo_threshold_ind(fifo_threshold_ind),
    .fifo_data         (fifo_data),
    .fifo_trans_read   (fifo_trans_read),
    .flush_req         (flush_req),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_last            (m_last),
    .busy              (busy)
  );

  always #5 clk_in = ~clk_in;

  assign fifo_empty_ind = (wr_ptr == rd_ptr);
  assign fifo_data      = mem[rd_ptr[5:0]];

  // FIFO read side; shares the DUT reset, which empties it.
  always @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_trans_read) begin
      rd_ptr <= rd_ptr + 1;
      npops  <= npops + 1;
    end
  end

  // Log every accepted output beat.
  always @(posedge clk_in) begin
    if (areset_b && m_valid && m_ready) begin
      bdata[nbeats[5:0]] <= m_data;
      blast[nbeats[5:0]] <= m_last;
      nbeats <= nbeats + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Wait for n beats from base, then check data is consecutive from first and
  // that m_last sits on every 4th beat and on the final one.
  task automatic expect_burst(input string tag, input int base, input logic [31:0] first, input int n);
    int k;
    logic [31:0] exp_d;
    k = 0;
    while (((nbeats - base) < n) && (k < 200)) begin
      step();
      k++;
    end
    repeat (3) step();
    check({tag, "_beats"}, 64'(nbeats - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      exp_d = first + 32'(i);
      check($sformatf("%s_data%0d", tag, i), 64'(bdata[6'(base + i)]), 64'(exp_d));
      check($sformatf("%s_last%0d", tag, i), 64'(blast[6'(base + i)]),
            64'(((i % 4) == 3) || (i == n - 1)));
    end
  endtask

  task automatic wait_pop(output int k);
    k = 0;
    while (!fifo_trans_read && (k < 40)) begin
      step();
      k++;
    end
  endtask

  task automatic wait_last(output int k);
    k = 0;
    while (!(m_valid && m_last) && (k < 60)) begin
      step();
      k++;
    end
  endtask

  initial begin
    int base;
    int pbase;
    int k;
    int bad;

    // Reset state.
    repeat (3) step();
    check("rst_valid", 64'(m_valid), 64'h0);
    check("rst_last", 64'(m_last), 64'h0);
    check("rst_data", 64'(m_data), 64'h0);
    check("rst_read", 64'(fifo_trans_read), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    areset_b = 1'b1;
    step();

    // Threshold-triggered full-rate bursts.
    base = nbeats;
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    fifo_threshold_ind = 1'b1;
    wait_pop(k);
    check("t1_pop_seen", 64'(fifo_trans_read), 64'h1);
    step();
    check("t1_valid_n1", 64'(m_valid), 64'h0);
    step();
    check("t1_valid_n2", 64'(m_valid), 64'h1);
    check("t1_data_n2", 64'(m_data), 64'h10);
    expect_burst("t1", base, 32'h10, 8);
    fifo_threshold_ind = 1'b0;
    step();
    check("t1_idle_busy", 64'(busy), 64'h0);

    // Idle timeout start, then wait timeout closes the short burst.
    base = nbeats;
    push(32'hA0);
    push(32'hA1);
    wait_pop(k);
    check("t2_pop_delay", 64'(k), 64'd16);
    wait_last(k);
    check("t2_last_delay", 64'(k), 64'd18);
    check("t2_last_data", 64'(m_data), 64'hA1);
    expect_burst("t2", base, 32'hA0, 2);

    // Flush drains immediately.
    base = nbeats;
    push(32'h1);
    push(32'h2);
    push(32'h3);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check("t3_immediate_pop", 64'(fifo_trans_read), 64'h1);
    expect_burst("t3", base, 32'h1, 3);
    check("t3_busy_after", 64'(busy), 64'h0);

    // Backpressure mid-burst.
    base  = nbeats;
    pbase = npops;
    for (int i = 0; i < 8; i++) push(32'h40 + 32'(i));
    fifo_threshold_ind = 1'b1;
    k = 0;
    while (!m_valid && (k < 20)) begin
      step();
      k++;
    end
    check("t4_pops_at_stall", 64'(npops - pbase), 64'd2);
    m_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(m_valid && (m_data == 32'h40) && !m_last)) bad++;
    end
    check("t4_stable_cycles_bad", 64'(bad), 64'h0);
    check("t4_pops_after_stall", 64'(npops - pbase), 64'd2);
    m_ready = 1'b1;
    expect_burst("t4", base, 32'h40, 8);
    fifo_threshold_ind = 1'b0;

    // Second word arrives while the first waits in hold.
    base = nbeats;
    push(32'h50);
    wait_pop(k);
    check("t5_pop_delay", 64'(k), 64'd16);
    repeat (6) step();
    check("t5_held_valid", 64'(m_valid), 64'h0);
    push(32'h51);
    wait_last(k);
    check("t5_last_delay", 64'(k), 64'd17);
    check("t5_last_data", 64'(m_data), 64'h51);
    expect_burst("t5", base, 32'h50, 2);

    // Reset while a beat is stalled on the output.
    for (int i = 0; i < 8; i++) push(32'h60 + 32'(i));
    fifo_threshold_ind = 1'b1;
    m_ready = 1'b0;
    k = 0;
    while (!m_valid && (k < 20)) begin
      step();
      k++;
    end
    check("t6_pre_valid", 64'(m_valid), 64'h1);
    areset_b = 1'b0;
    #1;
    check("t6_rst_valid", 64'(m_valid), 64'h0);
    check("t6_rst_last", 64'(m_last), 64'h0);
    check("t6_rst_data", 64'(m_data), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_read", 64'(fifo_trans_read), 64'h0);
    fifo_threshold_ind = 1'b0;
    m_ready = 1'b1;
    repeat (2) step();
    areset_b = 1'b1;
    step();
    base = nbeats;
    for (int i = 0; i < 4; i++) push(32'h70 + 32'(i));
    fifo_threshold_ind = 1'b1;
    expect_burst("t6", base, 32'h70, 4);
    fifo_threshold_ind = 1'b0;
    step();
    check("t6_end_busy", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
